// File: rtl/priority_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : priority_scan_pkg
// Description : Shared constants and helpers for the priority scan encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package priority_scan_pkg;

    localparam int c_default_n = 8;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_scan = 1'b1;

    // Index width for an n-source vector, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/priority_scan_encoder_lsb_find.sv
`default_nettype none
// ============================================================================
// Module      : lsb_find
// Description : Combinational lowest-set-bit finder with population flags.
// Revision    : 1.0 - initial release
// ============================================================================
module lsb_find
    import priority_scan_pkg::*;
#(
    parameter int N = c_default_n,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] index,
    output logic         any_set,
    output logic         one_hot_or_zero
);

    localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

    logic [W-1:0] w_index;
    logic         w_found;
    logic [N-1:0] w_minus_one;

    always_comb begin
        w_index = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && vec[i]) begin
                w_index = W'(i);
                w_found = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves zero exactly when at most one bit is set.
    assign w_minus_one     = vec - c_one;
    assign index           = w_index;
    assign any_set         = |vec;
    assign one_hot_or_zero = ((vec & w_minus_one) == '0);

endmodule
`default_nettype wire

// File: rtl/priority_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module      : priority_scan_encoder
// Description : Captures a request vector and reports its set bits, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_scan_encoder
    import priority_scan_pkg::*;
#(
    parameter int N = c_default_n,
    localparam int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_vec,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         out_zero
);

    localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

    generate
        if (N < 2 || N > 64) begin : g_bad_width
            $error("priority_scan_encoder: N must be within 2..64");
        end
    endgenerate

    logic [0:0]   r_state;
    logic [0:0]   w_state_next;
    logic [N-1:0] r_pend;
    logic [N-1:0] w_pend_next;

    logic [W-1:0] w_idx;
    logic         w_any_set;
    logic         w_one_or_zero;

    lsb_find #(
        .N (N)
    ) u_lsb_find (
        .vec             (r_pend),
        .index           (w_idx),
        .any_set         (w_any_set),
        .one_hot_or_zero (w_one_or_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pend_next  = r_pend;
        case (r_state)
            c_st_idle: begin
                if (in_valid) begin
                    w_state_next = c_st_scan;
                    w_pend_next  = in_vec;
                end
            end
            c_st_scan: begin
                if (out_ready) begin
                    if (w_one_or_zero) begin
                        w_state_next = c_st_idle;
                        w_pend_next  = '0;
                    end else begin
                        w_pend_next = r_pend & ~(c_one << w_idx);
                    end
                end
            end
            default: begin
                w_state_next = c_st_idle;
                w_pend_next  = '0;
            end
        endcase
    end

    // The pending vector only reads zero in SCAN when the captured vector was zero.
    always_comb begin
        in_ready  = (r_state == c_st_idle) && !rst;
        out_valid = 1'b0;
        out_idx   = '0;
        out_last  = 1'b0;
        out_zero  = 1'b0;
        if (r_state == c_st_scan) begin
            out_valid = 1'b1;
            out_idx   = w_idx;
            out_last  = w_one_or_zero;
            out_zero  = !w_any_set;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_priority_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_scan_encoder
// Description : Directed self-checking bench for priority_scan_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_scan_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] in_vec = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic       out_zero;

    logic [1:0] in_vec2 = '0;
    logic       in_valid2 = 1'b0;
    logic       in_ready2;
    logic [0:0] out_idx2;
    logic       out_valid2;
    logic       out_ready2 = 1'b0;
    logic       out_last2;
    logic       out_zero2;

    logic [63:0] in_vec64 = '0;
    logic        in_valid64 = 1'b0;
    logic        in_ready64;
    logic [5:0]  out_idx64;
    logic        out_valid64;
    logic        out_ready64 = 1'b0;
    logic        out_last64;
    logic        out_zero64;

    int checks = 0;
    int errors = 0;

    int b_idx  [0:63];
    bit b_last [0:63];
    bit b_zero [0:63];
    int b_cyc  [0:63];
    int b_cnt;
    bit b_rdy_last;
    bit b_timeout;

    always #5 clk = ~clk;

    priority_scan_encoder #(.N(8)) dut (
        .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready),
        .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_zero(out_zero)
    );

    priority_scan_encoder #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .in_vec(in_vec2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_idx(out_idx2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_last(out_last2), .out_zero(out_zero2)
    );

    priority_scan_encoder #(.N(64)) dut64 (
        .clk(clk), .rst(rst), .in_vec(in_vec64), .in_valid(in_valid64), .in_ready(in_ready64),
        .out_idx(out_idx64), .out_valid(out_valid64), .out_ready(out_ready64),
        .out_last(out_last64), .out_zero(out_zero64)
    );

    // Present a vector for one cycle; returns at the following falling edge.
    task automatic send(input logic [7:0] v);
        in_vec   = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Record beats with out_ready held high until the last beat or the budget runs out.
    task automatic collect(input int max_cyc, input bit garble);
        b_cnt      = 0;
        b_rdy_last = 1'b1;
        b_timeout  = 1'b1;
        out_ready  = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            if (out_valid && b_cnt < 64) begin
                b_idx[b_cnt]  = int'(out_idx);
                b_last[b_cnt] = out_last;
                b_zero[b_cnt] = out_zero;
                b_cyc[b_cnt]  = c;
                b_cnt++;
                if (out_last) begin
                    b_rdy_last = in_ready;
                    b_timeout  = 1'b0;
                    if (garble) in_valid = 1'b0;
                    break;
                end
            end
            if (garble) begin
                in_vec   = 8'($urandom);
                in_valid = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || in_ready2 !== 1'b0 || in_ready64 !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b%b%b expected 000", in_ready, in_ready2, in_ready64);
        end
        checks++;
        if ({out_valid, out_idx, out_last, out_zero} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000", {out_valid, out_idx, out_last, out_zero});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_before: got %b expected 1", in_ready);
        end
        send(8'h01);
        collect(10, 1'b0);
        checks++;
        if (b_timeout || b_cnt != 1 || b_idx[0] != 0 || b_last[0] !== 1'b1 || b_zero[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_beat: got cnt=%0d idx=%0d last=%b zero=%b expected cnt=1 idx=0 last=1 zero=0",
                     b_cnt, b_idx[0], b_last[0], b_zero[0]);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_after: got %b expected 1", in_ready);
        end
        checks++;
        if ({out_valid, out_idx, out_last, out_zero} !== 6'b0) begin
            errors++;
            $display("FAIL idle_outputs: got %b expected 000000", {out_valid, out_idx, out_last, out_zero});
        end
    endtask

    task automatic test_msb_then_three();
        send(8'h80);
        collect(10, 1'b0);
        checks++;
        if (b_timeout || b_cnt != 1 || b_idx[0] != 7 || b_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL msb_beat: got cnt=%0d idx=%0d last=%b expected cnt=1 idx=7 last=1",
                     b_cnt, b_idx[0], b_last[0]);
        end
        @(negedge clk);
        send(8'h07);
        collect(10, 1'b1);
        checks++;
        if (b_timeout || b_cnt != 3) begin
            errors++;
            $display("FAIL three_count: got %0d expected 3", b_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (b_idx[k] != k || b_last[k] !== (k == 2) || b_zero[k] !== 1'b0 || b_cyc[k] != k) begin
                errors++;
                $display("FAIL three_beat%0d: got idx=%0d last=%b zero=%b cyc=%0d expected idx=%0d last=%b zero=0 cyc=%0d",
                         k, b_idx[k], b_last[k], b_zero[k], b_cyc[k], k, (k == 2), k);
            end
        end
        checks++;
        if (b_rdy_last !== 1'b0) begin
            errors++;
            $display("FAIL ready_on_last: got %b expected 0", b_rdy_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL three_return_idle: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_stall();
        int exp_idx [0:5] = '{0, 1, 2, 4, 5, 6};
        int k = 0;
        int stalls = 0;
        bit done = 1'b0;
        out_ready = 1'b1;
        send(8'h77);
        for (int c = 0; c < 30 && !done; c++) begin
            if (out_valid) begin
                if (stalls == 0 && out_idx == 3'd1) begin
                    out_ready = 1'b0;
                    stalls    = 1;
                end else begin
                    if (stalls == 1 || stalls == 2) begin
                        checks++;
                        if (out_idx !== 3'd1 || out_last !== 1'b0 || out_zero !== 1'b0) begin
                            errors++;
                            $display("FAIL stall_hold%0d: got idx=%0d last=%b zero=%b expected idx=1 last=0 zero=0",
                                     stalls, out_idx, out_last, out_zero);
                        end
                    end
                    if (stalls == 1) begin
                        stalls = 2;
                    end else begin
                        if (stalls == 2) stalls = 3;
                        out_ready = 1'b1;
                        checks++;
                        if (k > 5 || out_idx != 3'(exp_idx[k]) || out_last !== (k == 5) || out_zero !== 1'b0) begin
                            errors++;
                            $display("FAIL stall_beat%0d: got idx=%0d last=%b zero=%b expected idx=%0d last=%b zero=0",
                                     k, out_idx, out_last, out_zero, (k > 5) ? -1 : exp_idx[k], (k == 5));
                        end
                        k++;
                        if (out_last) done = 1'b1;
                    end
                end
            end
            if (!done) @(negedge clk);
        end
        checks++;
        if (k != 6 || stalls != 3) begin
            errors++;
            $display("FAIL stall_count: got beats=%0d stalls=%0d expected beats=6 stalls=3", k, stalls);
        end
        @(negedge clk);
    endtask

    task automatic test_zero();
        send(8'h00);
        collect(10, 1'b0);
        checks++;
        if (b_timeout || b_cnt != 1 || b_idx[0] != 0 || b_last[0] !== 1'b1 || b_zero[0] !== 1'b1) begin
            errors++;
            $display("FAIL zero_beat: got cnt=%0d idx=%0d last=%b zero=%b expected cnt=1 idx=0 last=1 zero=1",
                     b_cnt, b_idx[0], b_last[0], b_zero[0]);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_zero !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_after: got valid=%b zero=%b ready=%b expected 0 0 1", out_valid, out_zero, in_ready);
        end
    endtask

    task automatic test_reset_mid_scan();
        out_ready = 1'b1;
        send(8'hFF);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'(k) || out_last !== 1'b0) begin
                errors++;
                $display("FAIL ff_beat%0d: got valid=%b idx=%0d last=%b expected valid=1 idx=%0d last=0",
                         k, out_valid, out_idx, out_last, k);
            end
            if (k < 2) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_idx, out_last, out_zero} !== 6'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midscan_reset: got out=%b ready=%b expected out=000000 ready=0",
                     {out_valid, out_idx, out_last, out_zero}, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midscan_release: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
        send(8'h02);
        collect(10, 1'b0);
        checks++;
        if (b_timeout || b_cnt != 1 || b_idx[0] != 1 || b_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_beat: got cnt=%0d idx=%0d last=%b expected cnt=1 idx=1 last=1",
                     b_cnt, b_idx[0], b_last[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_n2();
        int k = 0;
        in_vec2    = 2'b11;
        in_valid2  = 1'b1;
        out_ready2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid2) begin
                checks++;
                if (out_idx2 !== 1'(k) || out_last2 !== (k == 1) || out_zero2 !== 1'b0) begin
                    errors++;
                    $display("FAIL n2_beat%0d: got idx=%0d last=%b zero=%b expected idx=%0d last=%b zero=0",
                             k, out_idx2, out_last2, out_zero2, k, (k == 1));
                end
                k++;
                if (out_last2) break;
            end
            @(negedge clk);
        end
        checks++;
        if (k != 2) begin
            errors++;
            $display("FAIL n2_count: got %0d expected 2", k);
        end
        @(negedge clk);
    endtask

    task automatic test_n64();
        int k = 0;
        in_vec64    = '1;
        in_valid64  = 1'b1;
        out_ready64 = 1'b1;
        @(negedge clk);
        in_valid64 = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (out_valid64) begin
                checks++;
                if (out_idx64 !== 6'(k) || out_last64 !== (k == 63) || out_zero64 !== 1'b0) begin
                    errors++;
                    $display("FAIL n64_beat%0d: got idx=%0d last=%b zero=%b expected idx=%0d last=%b zero=0",
                             k, out_idx64, out_last64, out_zero64, k, (k == 63));
                end
                k++;
                if (out_last64) break;
            end
            @(negedge clk);
        end
        checks++;
        if (k != 64) begin
            errors++;
            $display("FAIL n64_count: got %0d expected 64", k);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_msb_then_three();
        test_stall();
        test_zero();
        test_reset_mid_scan();
        test_n2();
        test_n64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
